load_hazard_scoreboard: RTL and testbench
=========================================

Name: load_hazard_scoreboard

Overview:
- Parametrised successor to the single-cycle load-use detector in the decode stage.
- Tracks every outstanding load destination in a per-register countdown scoreboard, so load-to-use latency is configurable (LOAD_LAT).
- Arbitrates load-use stalls against data-memory freezes and IF/ID flushes.
- Sits between IF/ID and ID/EX; drives PC/IF-ID hold, ID/EX bubble and global freeze.

Parameters:
REG_ADDR_W, 3, register address width; scoreboard depth NREG = 2**REG_ADDR_W.
LOAD_LAT, 1, cycles after issue before load data is forwardable to EX (legal 1..7).
CNT_W, 16, perf counter width (used only with the optional feature).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
instr_valid_ifid  in  1  IF/ID holds a real instruction
opcode_ifid  in  5  IF/ID opcode, instr[15:11]
rs_ifid  in  REG_ADDR_W  IF/ID Rs field
rt_ifid  in  REG_ADDR_W  IF/ID Rt field
rd_ifid  in  REG_ADDR_W  IF/ID destination register (already muxed by decode)
flush_ifid  in  1  taken branch/jump kills IF/ID this cycle
dmem_stall  in  1  data memory busy; whole pipe frozen
pc_hold  out  1  hold PC
ifid_hold  out  1  hold IF/ID
idex_bubble  out  1  load NOP into ID/EX
pipe_freeze  out  1  freeze all pipeline registers
state_o  out  2  FSM state: 0 RUN, 1 LDSTALL, 2 FREEZE
sb_busy  out  NREG  bit i set when cnt[i] != 0

Behaviour:
- Source use (decoded from opcode_ifid):
  - No sources: 00000, 00001, 00010, 00011, 00100, 00110.
  - Rs only: 01000–01011, 10000, 10001, 10011, 10100–10111, 01100–01111, 00101, 00111, 10010.
  - LBI (11000) uses none.
  - All other opcodes use Rs and Rt.
  - ST/STU store data is forwarded at MEM and never stalls.
- hazard = instr_valid_ifid & ~flush_ifid & ((rs_used & cnt[rs]!=0) | (rt_used & cnt[rt]!=0)).
- issue = instr_valid_ifid & ~flush_ifid & ~hazard & ~dmem_stall.
- Scoreboard update:
  - Each cycle with ~dmem_stall, every nonzero cnt decrements by 1.
  - On issue of LD (10001), cnt[rd_ifid] is loaded with LOAD_LAT; the load overrides the decrement for that entry.
  - When dmem_stall=1, all counters hold.
- Result: a dependent instruction stalls exactly LOAD_LAT cycles. With LOAD_LAT=1 this matches the single-cycle load-use rule.
- Outputs, in priority order:
  - dmem_stall: pipe_freeze=pc_hold=ifid_hold=1, idex_bubble=0.
  - Else flush_ifid: idex_bubble=1, holds 0.
  - Else hazard: pc_hold=ifid_hold=idex_bubble=1.
  - Else all 0.
- FSM (registered, next state from the same priority):
  - dmem_stall → FREEZE.
  - Else hazard → LDSTALL.
  - Else → RUN.
  - Freeze entered mid-stall resumes LDSTALL after release if the hazard persists; counters are unchanged across the freeze.
- flush_ifid together with dmem_stall: freeze wins and the flush is ignored; the producer must hold flush_ifid until the freeze is released.
- Back-to-back loads to the same rd: the later issue reloads the count.
- Reset:
  - State RUN, all cnt 0, sb_busy 0.
  - While rst=1: pc_hold=ifid_hold=pipe_freeze=0, idex_bubble=1.
  - Reset during a stall drops the stall on the next cycle.

Optional Feature:
HDU_PERF_CNT_EN:
- Defined: adds outputs ldstall_cnt [CNT_W] and freeze_cnt [CNT_W].
  - Each increments once per cycle in LDSTALL / FREEZE respectively.
  - Both saturate at all-ones and clear on rst.
- Undefined: ports absent, no counter logic.

Test Plan:
- LOAD_LAT=1: LD r2 issues; next cycle ADD r3,r2,r1 in IF/ID → stall 1 cycle (pc_hold=idex_bubble=1), cycle after: issue, state RUN.
- LOAD_LAT=3: same sequence → exactly 3 stall cycles; sb_busy[2] = 1 for 3 cycles, then 0.
- LD r4 then ADDI r5,r6,#1 (Rt field=4) → no stall; LBI r4 behind LD r4 → no stall.
- Hazard pending + dmem_stall high for 2 cycles → FREEZE 2 cycles, counter held, then remaining stall cycles in LDSTALL.
- Hazard cycle with flush_ifid=1 → idex_bubble=1, pc_hold=0, no stall.
- rst asserted while in LDSTALL with cnt=2 → next cycle RUN, sb_busy=0; with HDU_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/load_hazard_scoreboard_if.sv
// IF/ID-to-hazard-unit bundle: decoded fields in, pipeline control out.
// Master drives the instruction fields; slave is the hazard unit.
interface load_hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 3
);
  localparam int NREG = 2**REG_ADDR_W;

  logic                  instr_valid_ifid;
  logic [4:0]            opcode_ifid;
  logic [REG_ADDR_W-1:0] rs_ifid;
  logic [REG_ADDR_W-1:0] rt_ifid;
  logic [REG_ADDR_W-1:0] rd_ifid;
  logic                  flush_ifid;
  logic                  dmem_stall;
  logic                  pc_hold;
  logic                  ifid_hold;
  logic                  idex_bubble;
  logic                  pipe_freeze;
  logic [1:0]            state_o;
  logic [NREG-1:0]       sb_busy;

  modport master (
    output instr_valid_ifid, opcode_ifid,
    output rs_ifid, rt_ifid, rd_ifid,
    output flush_ifid, dmem_stall,
    input  pc_hold, ifid_hold,
    input  idex_bubble, pipe_freeze,
    input  state_o, sb_busy
  );

  modport slave (
    input  instr_valid_ifid, opcode_ifid,
    input  rs_ifid, rt_ifid, rd_ifid,
    input  flush_ifid, dmem_stall,
    output pc_hold, ifid_hold,
    output idex_bubble, pipe_freeze,
    output state_o, sb_busy
  );
endinterface

// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard unit with per-register countdown scoreboard.
// Define HDU_PERF_CNT_EN to add saturating stall/freeze cycle counters.
module load_hazard_scoreboard #(
  parameter int REG_ADDR_W = 3,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic rst,
  load_hazard_scoreboard_if.slave bus
`ifdef HDU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] ldstall_cnt,
  output logic [CNT_W-1:0] freeze_cnt
`endif
);

  localparam int NREG = 2**REG_ADDR_W;
  localparam logic [2:0] LAT = 3'(LOAD_LAT);
  localparam logic [4:0] OP_LD = 5'b10001;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FREEZE  = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] cnt [NREG];

  logic rs_used;
  logic rt_used;
  logic rs_pend;
  logic rt_pend;
  logic live;
  logic hazard;
  logic issue;
  logic ld_issue;

  // Stores get their data forwarded at MEM, so Rt is never a stall source
  always_comb begin
    rs_used = 1'b1;
    rt_used = 1'b1;
    case (bus.opcode_ifid)
      5'b00000, 5'b00001, 5'b00010,
      5'b00011, 5'b00100, 5'b00110,
      5'b11000: begin
        rs_used = 1'b0;
        rt_used = 1'b0;
      end
      5'b01000, 5'b01001, 5'b01010,
      5'b01011, 5'b01100, 5'b01101,
      5'b01110, 5'b01111, 5'b10000,
      5'b10001, 5'b10010, 5'b10011,
      5'b10100, 5'b10101, 5'b10110,
      5'b10111, 5'b00101, 5'b00111: begin
        rt_used = 1'b0;
      end
      default: begin
        rs_used = 1'b1;
        rt_used = 1'b1;
      end
    endcase
  end

  assign rs_pend = cnt[bus.rs_ifid] != 3'd0;
  assign rt_pend = cnt[bus.rt_ifid] != 3'd0;
  assign live    = bus.instr_valid_ifid
                 & ~bus.flush_ifid;
  assign hazard  = live
                 & ((rs_used & rs_pend)
                 |  (rt_used & rt_pend));
  assign issue   = live & ~hazard
                 & ~bus.dmem_stall;
  assign ld_issue = issue
                  & (bus.opcode_ifid == OP_LD);

  // A freshly issued load overrides the decrement of its own entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        cnt[i] <= 3'd0;
    end else if (!bus.dmem_stall) begin
      for (int i = 0; i < NREG; i++) begin
        if (ld_issue &&
            bus.rd_ifid == REG_ADDR_W'(i))
          cnt[i] <= LAT;
        else if (cnt[i] != 3'd0)
          cnt[i] <= cnt[i] - 3'd1;
      end
    end
  end

  always_comb begin
    bus.sb_busy = '0;
    for (int i = 0; i < NREG; i++)
      bus.sb_busy[i] = cnt[i] != 3'd0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= RUN;
    else if (bus.dmem_stall)
      state <= FREEZE;
    else if (hazard)
      state <= LDSTALL;
    else
      state <= RUN;
  end

  assign bus.state_o = state;

  always_comb begin
    bus.pc_hold     = 1'b0;
    bus.ifid_hold   = 1'b0;
    bus.idex_bubble = 1'b0;
    bus.pipe_freeze = 1'b0;
    if (rst) begin
      bus.idex_bubble = 1'b1;
    end else if (bus.dmem_stall) begin
      bus.pipe_freeze = 1'b1;
      bus.pc_hold     = 1'b1;
      bus.ifid_hold   = 1'b1;
    end else if (bus.flush_ifid) begin
      bus.idex_bubble = 1'b1;
    end else if (hazard) begin
      bus.pc_hold     = 1'b1;
      bus.ifid_hold   = 1'b1;
      bus.idex_bubble = 1'b1;
    end
  end

`ifdef HDU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ldstall_cnt <= '0;
      freeze_cnt  <= '0;
    end else begin
      if (state == LDSTALL && ~&ldstall_cnt)
        ldstall_cnt <= ldstall_cnt + 1'b1;
      if (state == FREEZE && ~&freeze_cnt)
        freeze_cnt <= freeze_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Directed bench: dut_a runs LOAD_LAT=1, dut_b runs LOAD_LAT=3.
// Inputs change on the falling edge; outputs checked 1ns later.
module tb_load_hazard_scoreboard;

  localparam logic [4:0] LD   = 5'b10001;
  localparam logic [4:0] ADD  = 5'b11011;
  localparam logic [4:0] ADDI = 5'b01000;
  localparam logic [4:0] LBI  = 5'b11000;
  localparam logic [4:0] ST   = 5'b10000;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  load_hazard_scoreboard_if #(.REG_ADDR_W(3)) ifa ();
  load_hazard_scoreboard_if #(.REG_ADDR_W(3)) ifb ();

`ifdef HDU_PERF_CNT_EN
  logic [15:0] lc_a, fc_a, lc_b, fc_b;
`endif

  load_hazard_scoreboard #(
    .REG_ADDR_W(3), .LOAD_LAT(1), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa.slave)
`ifdef HDU_PERF_CNT_EN
    , .ldstall_cnt(lc_a), .freeze_cnt(fc_a)
`endif
  );

  load_hazard_scoreboard #(
    .REG_ADDR_W(3), .LOAD_LAT(3), .CNT_W(16)
  ) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb.slave)
`ifdef HDU_PERF_CNT_EN
    , .ldstall_cnt(lc_b), .freeze_cnt(fc_b)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic v, input logic [4:0] op,
                       input logic [2:0] rs, input logic [2:0] rt,
                       input logic [2:0] rd, input logic fl,
                       input logic ds);
    @(negedge clk);
    ifa.instr_valid_ifid = v;
    ifa.opcode_ifid = op;
    ifa.rs_ifid = rs;
    ifa.rt_ifid = rt;
    ifa.rd_ifid = rd;
    ifa.flush_ifid = fl;
    ifa.dmem_stall = ds;
    #1;
  endtask

  task automatic set_b(input logic v, input logic [4:0] op,
                       input logic [2:0] rs, input logic [2:0] rt,
                       input logic [2:0] rd, input logic ds,
                       input logic r);
    @(negedge clk);
    rst_b = r;
    ifb.instr_valid_ifid = v;
    ifb.opcode_ifid = op;
    ifb.rs_ifid = rs;
    ifb.rt_ifid = rt;
    ifb.rd_ifid = rd;
    ifb.flush_ifid = 1'b0;
    ifb.dmem_stall = ds;
    #1;
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    set_a(0, 5'd0, 0, 0, 0, 0, 0);
    set_b(0, 5'd0, 0, 0, 0, 0, 1);
    chk("rst_bubble", 32'(ifa.idex_bubble), 32'd1);
    chk("rst_pc_hold", 32'(ifa.pc_hold), 32'd0);
    chk("rst_freeze", 32'(ifa.pipe_freeze), 32'd0);
    set_a(0, 5'd0, 0, 0, 0, 0, 0);
    set_b(0, 5'd0, 0, 0, 0, 0, 1);
    rst_a = 1'b0;
    set_a(0, 5'd0, 0, 0, 0, 0, 0);
    chk("rst_state", 32'(ifa.state_o), 32'd0);
    chk("rst_busy", 32'(ifa.sb_busy), 32'd0);
    chk("rst_bubble_off", 32'(ifa.idex_bubble), 32'd0);

    // LOAD_LAT=1: LD r2 then ADD r3,r2,r1
    set_a(1, LD, 1, 0, 2, 0, 0);
    chk("a_ld_no_hold", 32'(ifa.pc_hold), 32'd0);
    set_a(1, ADD, 2, 1, 3, 0, 0);
    chk("a_stall_pc", 32'(ifa.pc_hold), 32'd1);
    chk("a_stall_ifid", 32'(ifa.ifid_hold), 32'd1);
    chk("a_stall_bub", 32'(ifa.idex_bubble), 32'd1);
    chk("a_stall_busy", 32'(ifa.sb_busy), 32'h04);
    set_a(1, ADD, 2, 1, 3, 0, 0);
    chk("a_issue_pc", 32'(ifa.pc_hold), 32'd0);
    chk("a_issue_bub", 32'(ifa.idex_bubble), 32'd0);
    chk("a_state_ld", 32'(ifa.state_o), 32'd1);
    chk("a_busy_clr", 32'(ifa.sb_busy), 32'h00);
    set_a(0, 5'd0, 0, 0, 0, 0, 0);
    chk("a_state_run", 32'(ifa.state_o), 32'd0);

    // Rt of an Rs-only op, LBI and store data never stall
    set_a(1, LD, 0, 0, 4, 0, 0);
    set_a(1, ADDI, 6, 4, 5, 0, 0);
    chk("a_addi_nostall", 32'(ifa.pc_hold), 32'd0);
    set_a(1, LD, 0, 0, 4, 0, 0);
    set_a(1, LBI, 4, 4, 4, 0, 0);
    chk("a_lbi_nostall", 32'(ifa.pc_hold), 32'd0);
    set_a(1, LD, 0, 0, 2, 0, 0);
    set_a(1, ST, 1, 2, 0, 0, 0);
    chk("a_st_nostall", 32'(ifa.pc_hold), 32'd0);

    // Flush on a hazard cycle: bubble only
    set_a(1, LD, 0, 0, 2, 0, 0);
    set_a(1, ADD, 2, 1, 3, 1, 0);
    chk("a_fl_bub", 32'(ifa.idex_bubble), 32'd1);
    chk("a_fl_pc", 32'(ifa.pc_hold), 32'd0);
    chk("a_fl_ifid", 32'(ifa.ifid_hold), 32'd0);
    set_a(0, 5'd0, 0, 0, 0, 0, 0);
    chk("a_fl_state", 32'(ifa.state_o), 32'd0);

    // LOAD_LAT=3: exactly three stall cycles
    set_b(0, 5'd0, 0, 0, 0, 0, 0);
    chk("b_rst_state", 32'(ifb.state_o), 32'd0);
    set_b(1, LD, 1, 0, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      set_b(1, ADD, 2, 1, 3, 0, 0);
      chk($sformatf("b_stall%0d", i),
          32'(ifb.pc_hold), 32'd1);
      chk($sformatf("b_busy%0d", i),
          32'(ifb.sb_busy[2]), 32'd1);
    end
    set_b(1, ADD, 2, 1, 3, 0, 0);
    chk("b_issue", 32'(ifb.pc_hold), 32'd0);
    chk("b_busy_clr", 32'(ifb.sb_busy[2]), 32'd0);
    chk("b_state_ld", 32'(ifb.state_o), 32'd1);
    set_b(0, 5'd0, 0, 0, 0, 0, 0);
    chk("b_state_run", 32'(ifb.state_o), 32'd0);

    // Freeze for two cycles in the middle of a stall
    set_b(1, LD, 1, 0, 2, 0, 0);
    set_b(1, ADD, 2, 1, 3, 0, 0);
    chk("fz_pre_stall", 32'(ifb.pc_hold), 32'd1);
    set_b(1, ADD, 2, 1, 3, 1, 0);
    chk("fz_freeze", 32'(ifb.pipe_freeze), 32'd1);
    chk("fz_pc", 32'(ifb.pc_hold), 32'd1);
    chk("fz_bub", 32'(ifb.idex_bubble), 32'd0);
    set_b(1, ADD, 2, 1, 3, 1, 0);
    chk("fz_state", 32'(ifb.state_o), 32'd2);
    set_b(1, ADD, 2, 1, 3, 0, 0);
    chk("fz_rel_stall", 32'(ifb.pc_hold), 32'd1);
    chk("fz_rel_bub", 32'(ifb.idex_bubble), 32'd1);
    chk("fz_rel_frz", 32'(ifb.pipe_freeze), 32'd0);
    chk("fz_rel_state", 32'(ifb.state_o), 32'd2);
    set_b(1, ADD, 2, 1, 3, 0, 0);
    chk("fz_last_stall", 32'(ifb.pc_hold), 32'd1);
    chk("fz_resume", 32'(ifb.state_o), 32'd1);
    set_b(1, ADD, 2, 1, 3, 0, 0);
    chk("fz_issue", 32'(ifb.pc_hold), 32'd0);

    // Second load to the same rd reloads the count
    set_b(1, LD, 0, 0, 4, 0, 0);
    set_b(0, 5'd0, 0, 0, 0, 0, 0);
    set_b(1, LD, 0, 0, 4, 0, 0);
    set_b(0, 5'd0, 0, 0, 0, 0, 0);
    set_b(0, 5'd0, 0, 0, 0, 0, 0);
    chk("rl_busy", 32'(ifb.sb_busy[4]), 32'd1);
    set_b(0, 5'd0, 0, 0, 0, 0, 0);
    set_b(0, 5'd0, 0, 0, 0, 0, 0);
    chk("rl_done", 32'(ifb.sb_busy[4]), 32'd0);

    // Reset while stalled with cnt=2
    set_b(1, LD, 1, 0, 2, 0, 0);
    set_b(1, ADD, 2, 1, 3, 0, 0);
    set_b(1, ADD, 2, 1, 3, 0, 1);
    chk("rs_cnt2", 32'(ifb.sb_busy), 32'h04);
    chk("rs_in_ld", 32'(ifb.state_o), 32'd1);
    chk("rs_pc", 32'(ifb.pc_hold), 32'd0);
    chk("rs_bub", 32'(ifb.idex_bubble), 32'd1);
    set_b(1, ADD, 2, 1, 3, 0, 0);
    chk("rs_state", 32'(ifb.state_o), 32'd0);
    chk("rs_busy", 32'(ifb.sb_busy), 32'h00);
    chk("rs_nostall", 32'(ifb.pc_hold), 32'd0);
`ifdef HDU_PERF_CNT_EN
    chk("rs_lcnt", 32'(lc_b), 32'd0);
    chk("rs_fcnt", 32'(fc_b), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
